// File: rtl/avs_sram_ctrl_pkg.sv
// Shared types and widths for the Avalon-MM to async SRAM bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: sram_state_t controller state encoding, SRAM_DW halfword data
// width, AVS_DW Avalon word data width.
package sram_ctrl_pkg;

   localparam int SRAM_DW = 16;
   localparam int AVS_DW  = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_LO   = 3'd1,
      RD_HI   = 3'd2,
      WR_LO_S = 3'd3,
      WR_LO_P = 3'd4,
      WR_HI_S = 3'd5,
      WR_HI_P = 3'd6,
      DONE    = 3'd7
   } sram_state_t;

endpackage

// File: rtl/avs_sram_ctrl.sv
// Avalon-MM slave bridging 32-bit word accesses onto a 16-bit async SRAM.
// Latency: read 4 cycles, write 6 (both halves) / 4 (one half) / 2 (be=0).
// Backpressure: avs_waitrequest high except in the single DONE cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   avs_address/read/write    Avalon word address and held requests
//   avs_writedata/byteenable  write data and byte lanes
//   avs_readdata              read data, held until the next read capture
//   avs_waitrequest           low only in the completion cycle
//   sram_ce_n/oe_n/we_n/be_n  registered active-low SRAM strobes
//   sram_addr                 registered halfword address
//   sram_dq                   bidirectional data, driven only in write states
module avs_sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int SRAM_AW = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SRAM_AW-2:0] avs_address,
   input  logic               avs_read,
   input  logic               avs_write,
   input  logic [AVS_DW-1:0]  avs_writedata,
   input  logic [3:0]         avs_byteenable,
   output logic [AVS_DW-1:0]  avs_readdata,
   output logic               avs_waitrequest,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic [1:0]         sram_be_n,
   output logic [SRAM_AW-1:0] sram_addr,
   inout  wire  [SRAM_DW-1:0] sram_dq
);

   sram_state_t        state;
   logic [SRAM_AW-2:0] addr_q;
   logic [SRAM_DW-1:0] wdata_hi_q;
   logic [1:0]         be_hi_q;
   logic               dq_oe;
   logic [SRAM_DW-1:0] dq_out;

   assign sram_dq         = dq_oe ? dq_out : {SRAM_DW{1'bz}};
   assign avs_waitrequest = (state != DONE);

   // Pins are registered alongside the state: every transition loads the
   // pin values belonging to the state being entered, so the pads never
   // see decode glitches and each state holds its pins for a full cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         addr_q       <= '0;
         wdata_hi_q   <= '0;
         be_hi_q      <= '0;
         dq_oe        <= 1'b0;
         dq_out       <= '0;
         avs_readdata <= '0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_be_n    <= 2'b11;
         sram_addr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Read has priority when both requests are presented.
               if (avs_read) begin
                  addr_q    <= avs_address;
                  sram_addr <= {avs_address, 1'b0};
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= 1'b0;
                  sram_we_n <= 1'b1;
                  sram_be_n <= 2'b00;
                  state     <= RD_LO;
               end else if (avs_write) begin
                  addr_q     <= avs_address;
                  wdata_hi_q <= avs_writedata[31:16];
                  be_hi_q    <= avs_byteenable[3:2];
                  if (|avs_byteenable[1:0]) begin
                     sram_addr <= {avs_address, 1'b0};
                     sram_be_n <= ~avs_byteenable[1:0];
                     dq_out    <= avs_writedata[15:0];
                     sram_ce_n <= 1'b0;
                     sram_oe_n <= 1'b1;
                     sram_we_n <= 1'b1;
                     dq_oe     <= 1'b1;
                     state     <= WR_LO_S;
                  end else if (|avs_byteenable[3:2]) begin
                     sram_addr <= {avs_address, 1'b1};
                     sram_be_n <= ~avs_byteenable[3:2];
                     dq_out    <= avs_writedata[31:16];
                     sram_ce_n <= 1'b0;
                     sram_oe_n <= 1'b1;
                     sram_we_n <= 1'b1;
                     dq_oe     <= 1'b1;
                     state     <= WR_HI_S;
                  end else begin
                     // Nothing enabled: complete without touching the SRAM.
                     state <= DONE;
                  end
               end
            end
            RD_LO: begin
               avs_readdata[15:0] <= sram_dq;
               sram_addr          <= {addr_q, 1'b1};
               state              <= RD_HI;
            end
            RD_HI: begin
               avs_readdata[31:16] <= sram_dq;
               sram_ce_n           <= 1'b1;
               sram_oe_n           <= 1'b1;
               sram_be_n           <= 2'b11;
               state               <= DONE;
            end
            WR_LO_S: begin
               sram_we_n <= 1'b0;
               state     <= WR_LO_P;
            end
            WR_LO_P: begin
               sram_we_n <= 1'b1;
               if (|be_hi_q) begin
                  // Next setup cycle re-addresses while we_n is high again,
                  // giving the high half its own full cycle of address setup.
                  sram_addr <= {addr_q, 1'b1};
                  sram_be_n <= ~be_hi_q;
                  dq_out    <= wdata_hi_q;
                  state     <= WR_HI_S;
               end else begin
                  sram_ce_n <= 1'b1;
                  sram_be_n <= 2'b11;
                  dq_oe     <= 1'b0;
                  state     <= DONE;
               end
            end
            WR_HI_S: begin
               sram_we_n <= 1'b0;
               state     <= WR_HI_P;
            end
            WR_HI_P: begin
               sram_we_n <= 1'b1;
               sram_ce_n <= 1'b1;
               sram_be_n <= 2'b11;
               dq_oe     <= 1'b0;
               state     <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avs_sram_ctrl.sv
// Directed self-checking bench for avs_sram_ctrl with an async SRAM model.
// Latency: n/a (testbench).
// Backpressure: master holds requests until waitrequest drops.
module tb_avs_sram_ctrl;
   import sram_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic [1:0]  sram_be_n;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;

   always #5 clk = ~clk;

   avs_sram_ctrl #(.SRAM_AW(18)) dut (
      .clk             (clk),
      .rst             (rst),
      .avs_address     (avs_address),
      .avs_read        (avs_read),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_byteenable  (avs_byteenable),
      .avs_readdata    (avs_readdata),
      .avs_waitrequest (avs_waitrequest),
      .sram_ce_n       (sram_ce_n),
      .sram_oe_n       (sram_oe_n),
      .sram_we_n       (sram_we_n),
      .sram_be_n       (sram_be_n),
      .sram_addr       (sram_addr),
      .sram_dq         (sram_dq)
   );

   // Async SRAM model: drives dq while reading, latches on we_n rising.
   logic [15:0] mem [0:(1<<18)-1];
   wire         mem_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
   assign sram_dq = mem_drive ? mem[sram_addr] : 16'hzzzz;

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_be_n[0]) mem[sram_addr][7:0]  <= sram_dq[7:0];
         if (!sram_be_n[1]) mem[sram_addr][15:8] <= sram_dq[15:8];
      end
   end

   // Reference word memory and scoreboard of expected read data.
   logic [31:0] ref_mem [int];
   logic [31:0] sb [$];

   // Pin activity monitor, per-operation counters cleared by the op task.
   int          ce_cyc, pulse_cnt, run, max_run, lo_cnt, addr_bad, setup_bad;
   int          contention = 0;
   logic [1:0]  pulse_be_n;
   logic        prev_we_n = 1'b1;
   logic        prev_ce_n = 1'b1;
   logic [17:0] prev_addr = '0;
   logic [16:0] cur_addr;

   always @(negedge clk) begin
      if (!sram_ce_n) begin
         ce_cyc++;
         if (sram_addr[17:1] !== cur_addr) addr_bad++;
         if (!sram_addr[0]) lo_cnt++;
      end
      if (!sram_we_n) begin
         run++;
         if (run > max_run) max_run = run;
         pulse_be_n = sram_be_n;
         if (prev_we_n) begin
            pulse_cnt++;
            if (prev_ce_n || prev_addr !== sram_addr) setup_bad++;
         end
      end else begin
         run = 0;
      end
      if (!sram_oe_n && dut.dq_oe) contention++;
      prev_we_n = sram_we_n;
      prev_ce_n = sram_ce_n;
      prev_addr = sram_addr;
   end

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] last_rd;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic rd, input logic wr, input logic [16:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int exp_cyc, input string tag);
      int   cyc;
      logic done;
      @(negedge clk);
      #1;
      ce_cyc = 0; pulse_cnt = 0; run = 0; max_run = 0;
      lo_cnt = 0; addr_bad = 0; setup_bad = 0; pulse_be_n = 2'b11;
      cur_addr = a;
      if (rd) sb.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0);
      avs_read = rd; avs_write = wr; avs_address = a;
      avs_writedata = wd; avs_byteenable = be;
      cyc = 0; done = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         #1;
         cyc++;
         if (!avs_waitrequest) done = 1'b1;
      end
      chk(32'(done), 32'd1, {tag, " completes"});
      chk(cyc, exp_cyc, {tag, " cycles"});
      if (rd) begin
         chk(avs_readdata, sb.pop_front(), {tag, " rdata"});
         last_rd = avs_readdata;
      end else if (wr) begin
         logic [31:0] w;
         w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
         for (int b = 0; b < 4; b++)
            if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
         ref_mem[int'(a)] = w;
      end
      avs_read = 1'b0; avs_write = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      avs_read = 1'b0; avs_write = 1'b0; avs_address = '0;
      avs_writedata = '0; avs_byteenable = '0;
      mem[18'h3FFFE] = 16'h5678;
      mem[18'h3FFFF] = 16'h1234;
      ref_mem[32'h1FFFF] = 32'h12345678;
      repeat (3) @(negedge clk);
      #1;
      chk(32'(sram_ce_n), 32'd1, "rst ce_n");
      chk(32'(sram_oe_n), 32'd1, "rst oe_n");
      chk(32'(sram_we_n), 32'd1, "rst we_n");
      chk(32'(sram_be_n), 32'h3, "rst be_n");
      chk(32'(sram_addr), 32'h0, "rst addr");
      chk(avs_readdata, 32'h0, "rst rdata");
      chk(32'(avs_waitrequest), 32'd1, "rst waitreq");
      chk(32'(dut.dq_oe), 32'd0, "rst dq_oe");
      rst = 1'b0;

      // Full-word write then read.
      op(1'b0, 1'b1, 17'h100, 32'hDEADBEEF, 4'hF, 5, "wr full");
      chk(pulse_cnt, 2, "wr full pulses");
      chk(max_run, 1, "wr full pulse width");
      chk(setup_bad, 0, "wr full addr setup");
      chk(addr_bad, 0, "wr full addr");
      chk(32'(mem[18'h200]), 32'hBEEF, "mem 0x200");
      chk(32'(mem[18'h201]), 32'hDEAD, "mem 0x201");
      op(1'b1, 1'b0, 17'h100, 32'h0, 4'h0, 3, "rd full");

      // Partial write over an existing word.
      op(1'b0, 1'b1, 17'h100, 32'h11223344, 4'hF, 5, "wr base");
      chk(avs_readdata, last_rd, "rdata held over write");
      op(1'b0, 1'b1, 17'h100, 32'h00AA0000, 4'h4, 3, "wr partial");
      chk(pulse_cnt, 1, "wr partial pulses");
      chk(lo_cnt, 0, "wr partial lo visits");
      chk(32'(pulse_be_n), 32'h2, "wr partial be_n");
      op(1'b1, 1'b0, 17'h100, 32'h0, 4'h0, 3, "rd partial");

      // Zero byteenable: no pin activity.
      op(1'b0, 1'b1, 17'h100, 32'hFFFFFFFF, 4'h0, 1, "wr be0");
      chk(ce_cyc, 0, "wr be0 ce activity");
      op(1'b1, 1'b0, 17'h100, 32'h0, 4'h0, 3, "rd after be0");

      // Simultaneous read and write: read wins.
      op(1'b1, 1'b1, 17'h100, 32'h0, 4'hF, 3, "rd+wr");
      chk(pulse_cnt, 0, "rd+wr pulses");
      op(1'b1, 1'b0, 17'h100, 32'h0, 4'h0, 3, "rd after rd+wr");

      // Reset during the first write pulse.
      @(negedge clk);
      #1;
      avs_address = 17'h300; avs_writedata = 32'h55AA55AA;
      avs_byteenable = 4'hF; avs_write = 1'b1;
      n = 0;
      while (sram_we_n && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(32'(sram_we_n), 32'd0, "rst-mid pulse reached");
      rst = 1'b1; avs_write = 1'b0;
      @(negedge clk);
      #1;
      chk(32'(sram_we_n), 32'd1, "rst-mid we_n");
      chk(32'(sram_ce_n), 32'd1, "rst-mid ce_n");
      chk(32'(dut.dq_oe), 32'd0, "rst-mid dq_oe");
      chk(32'(dut.state), 32'(IDLE), "rst-mid state");
      rst = 1'b0;
      op(1'b1, 1'b0, 17'h100, 32'h0, 4'h0, 3, "rd after rst");

      // Back-to-back at the top address.
      op(1'b1, 1'b0, 17'h1FFFF, 32'h0, 4'h0, 3, "top rd1");
      chk(addr_bad, 0, "top rd1 addr");
      op(1'b0, 1'b1, 17'h1FFFF, 32'hCAFEF00D, 4'hF, 5, "top wr");
      chk(addr_bad, 0, "top wr addr");
      chk(32'(mem[18'h3FFFE]), 32'hF00D, "mem 0x3FFFE");
      chk(32'(mem[18'h3FFFF]), 32'hCAFE, "mem 0x3FFFF");
      op(1'b1, 1'b0, 17'h1FFFF, 32'h0, 4'h0, 3, "top rd2");
      chk(addr_bad, 0, "top rd2 addr");
      chk(contention, 0, "oe_n/dq contention");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
